hs32_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the user-project SRAM shared between the HS32 core memory port and the Caravel management Wishbone slave port. It serialises both requesters onto one single-port synchronous SRAM with 1-cycle read latency. Ties are resolved round-robin, and each transaction is acknowledged with a one-cycle ack. It sits in the user project wrapper between `core1` / `wbs_*` and the SRAM macro.

---
 rtl/hs32_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_hs32_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hs32_mem_arbiter
// Description : Round-robin arbiter and sequencer that shares one single-port
//               synchronous SRAM (1-cycle read latency) between the HS32 core
//               memory port and the Caravel management Wishbone slave port.
//               Every transaction runs IDLE -> ISSUE -> WAIT -> ACK and is
//               acknowledged with a one-cycle pulse on the granted port.
// Ports       : wb_clk_i / wb_rst_i       clock, async active-high reset
//               core_*                    HS32 core request/response port
//               wbs_*                     Wishbone classic slave port
//               ram_*                     SRAM macro interface
//               busy_o                    high whenever the FSM is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module hs32_mem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    // HS32 core port
    input  logic              core_stb_i,
    input  logic              core_rw_i,
    input  logic [31:0]       core_addr_i,
    input  logic [31:0]       core_dtw_i,
    output logic [31:0]       core_dtr_o,
    output logic              core_ack_o,
    // Wishbone slave port
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    // SRAM macro
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    // Status
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic GNT_CORE = 1'b0;
    localparam logic GNT_WB   = 1'b1;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ram_en_q, ram_en_d;
    logic [3:0]          ram_we_q, ram_we_d;
    logic [31:0]         core_dtr_q, core_dtr_d;
    logic [31:0]         wbs_dat_q, wbs_dat_d;
    logic                core_ack_q, core_ack_d;
    logic                wbs_ack_q, wbs_ack_d;

    logic                w_core_req;
    logic                w_wb_req;
    logic                w_pick_wb;

    // Word-address bits outside [ADDR_W+1:2] alias away on purpose.
    logic                w_unused_addr;
    assign w_unused_addr = &{1'b0, core_addr_i[31:ADDR_W+2], core_addr_i[1:0],
                             wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

    assign w_core_req = core_stb_i;
    assign w_wb_req   = wbs_cyc_i & wbs_stb_i;
    // On a tie the port that did not win last time gets the grant.
    assign w_pick_wb  = w_wb_req & (~w_core_req | (last_grant_q == GNT_CORE));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_WB;
            grant_q      <= GNT_CORE;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 4'h0;
            core_dtr_q   <= 32'h0;
            wbs_dat_q    <= 32'h0;
            core_ack_q   <= 1'b0;
            wbs_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            core_dtr_q   <= core_dtr_d;
            wbs_dat_q    <= wbs_dat_d;
            core_ack_q   <= core_ack_d;
            wbs_ack_q    <= wbs_ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        rd_d         = rd_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_dtr_d   = core_dtr_q;
        wbs_dat_d    = wbs_dat_q;
        // Strobe, enables and acks are single-cycle pulses.
        ram_en_d     = 1'b0;
        ram_we_d     = 4'h0;
        core_ack_d   = 1'b0;
        wbs_ack_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_core_req | w_wb_req) begin
                    state_d      = S_ISSUE;
                    grant_d      = w_pick_wb;
                    last_grant_d = w_pick_wb;
                    // The SRAM strobe is registered so it appears in ISSUE.
                    ram_en_d     = 1'b1;
                    if (w_pick_wb) begin
                        addr_d   = wbs_adr_i[ADDR_W+1:2];
                        wdata_d  = wbs_dat_i;
                        rd_d     = ~wbs_we_i;
                        ram_we_d = wbs_we_i ? wbs_sel_i : 4'h0;
                    end else begin
                        addr_d   = core_addr_i[ADDR_W+1:2];
                        wdata_d  = core_dtw_i;
                        rd_d     = ~core_rw_i;
                        ram_we_d = core_rw_i ? 4'hF : 4'h0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_ACK;
                // Read data is valid now, one cycle after the strobe.
                if (rd_q) begin
                    if (grant_q == GNT_WB) begin
                        wbs_dat_d = ram_rdata_i;
                    end else begin
                        core_dtr_d = ram_rdata_i;
                    end
                end
                if (grant_q == GNT_WB) begin
                    wbs_ack_d = 1'b1;
                end else begin
                    core_ack_d = 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign core_dtr_o  = core_dtr_q;
    assign core_ack_o  = core_ack_q;
    assign wbs_dat_o   = wbs_dat_q;
    assign wbs_ack_o   = wbs_ack_q;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hs32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs32_mem_arbiter
// Description : Self-checking bench for hs32_mem_arbiter. A behavioural SRAM
//               sits on the ram_* port; a reference memory predicts read data
//               and per-port queues hold the expected responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs32_mem_arbiter;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_stb_i = 1'b0, core_rw_i = 1'b0;
    logic [31:0]       core_addr_i = 32'h0, core_dtw_i = 32'h0;
    logic [31:0]       core_dtr_o;
    logic              core_ack_o;
    logic              wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]        wbs_sel_i = 4'h0;
    logic [31:0]       wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic [31:0]       wbs_dat_o;
    logic              wbs_ack_o;
    logic              ram_en_o;
    logic [3:0]        ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [31:0]       ram_wdata_o;
    logic [31:0]       ram_rdata_i = 32'h0;
    logic              busy_o;

    hs32_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .core_stb_i (core_stb_i),
        .core_rw_i  (core_rw_i),
        .core_addr_i(core_addr_i),
        .core_dtw_i (core_dtw_i),
        .core_dtr_o (core_dtr_o),
        .core_ack_o (core_ack_o),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_ack_o  (wbs_ack_o),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: byte-masked write, read data one cycle after strobe.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            end
            ram_rdata_i <= mem[ram_addr_o];
        end
    end

    // Reference memory used to predict read results.
    logic [31:0] ref_mem [0:1023];

    typedef struct {
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t core_q[$];
    exp_t wb_q[$];
    int   order[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks read-data registers.
    logic [31:0] core_dat_exp = 32'h0;
    logic [31:0] wb_dat_exp   = 32'h0;
    logic [ADDR_W-1:0] en_addr = '0;
    logic [3:0]        en_we   = 4'h0;
    int                en_cyc  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            core_dat_exp = 32'h0;
            wb_dat_exp   = 32'h0;
        end else begin
            if (ram_en_o) begin
                en_addr = ram_addr_o;
                en_we   = ram_we_o;
                en_cyc  = cyc;
            end
            if (core_ack_o) begin
                if (core_q.size() == 0) begin
                    check("core_spurious_ack", {31'h0, core_ack_o}, 32'h0);
                end else begin
                    e = core_q.pop_front();
                    if (e.rd) core_dat_exp = e.data;
                    order.push_back(0);
                end
            end
            if (wbs_ack_o) begin
                if (wb_q.size() == 0) begin
                    check("wbs_spurious_ack", {31'h0, wbs_ack_o}, 32'h0);
                end else begin
                    e = wb_q.pop_front();
                    if (e.rd) wb_dat_exp = e.data;
                    order.push_back(1);
                end
            end
            check("core_dtr", core_dtr_o, core_dat_exp);
            check("wbs_dat", wbs_dat_o, wb_dat_exp);
            check("dual_ack", {31'h0, core_ack_o & wbs_ack_o}, 32'h0);
        end
    end

    // Transactions are started just after a rising edge.
    task automatic core_txn(input logic rw, input logic [31:0] addr, input logic [31:0] dat,
                            output int st, output int ak);
        exp_t e;
        e.rd   = ~rw;
        e.data = ref_mem[addr[11:2]];
        if (rw) ref_mem[addr[11:2]] = dat;
        core_q.push_back(e);
        core_rw_i   = rw;
        core_addr_i = addr;
        core_dtw_i  = dat;
        core_stb_i  = 1'b1;
        st = cyc;
        ak = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (core_ack_o) begin
                ak = cyc;
                break;
            end
        end
        if (ak < 0) check("core_ack_timeout", {31'h0, core_ack_o}, 32'h1);
        @(posedge clk);
        #1 core_stb_i = 1'b0;
    endtask

    task automatic wb_txn(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] dat, output int st, output int ak);
        exp_t e;
        e.rd   = ~we;
        e.data = ref_mem[addr[11:2]];
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) ref_mem[addr[11:2]][8*b +: 8] = dat[8*b +: 8];
            end
        end
        wb_q.push_back(e);
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = addr;
        wbs_dat_i = dat;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        st = cyc;
        ak = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                ak = cyc;
                break;
            end
        end
        if (ak < 0) check("wbs_ack_timeout", {31'h0, wbs_ack_o}, 32'h1);
        @(posedge clk);
        #1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
    endtask

    task automatic preload(input int w, input logic [31:0] v);
        mem[w]     = v;
        ref_mem[w] = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_ack"}, {31'h0, core_ack_o}, 32'h0);
        check({tag, "_wbs_ack"},  {31'h0, wbs_ack_o}, 32'h0);
        check({tag, "_ram_en"},   {31'h0, ram_en_o}, 32'h0);
        check({tag, "_ram_we"},   {28'h0, ram_we_o}, 32'h0);
        check({tag, "_busy"},     {31'h0, busy_o}, 32'h0);
        check({tag, "_core_dtr"}, core_dtr_o, 32'h0);
        check({tag, "_wbs_dat"},  wbs_dat_o, 32'h0);
        check({tag, "_ram_addr"}, {22'h0, ram_addr_o}, 32'h0);
        check({tag, "_ram_wdata"}, ram_wdata_o, 32'h0);
    endtask

    initial begin
        int cs0, ca0, cs1, ca1, ws0, wa0, ws1, wa1;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Core read of word 5
        preload(5, 32'hCAFE0005);
        core_txn(1'b0, 32'h14, 32'h0, cs0, ca0);
        check("core_rd_lat", ca0 - cs0, 32'd3);
        check("core_rd_en_cyc", en_cyc - cs0, 32'd1);
        check("core_rd_addr", {22'h0, en_addr}, 32'd5);
        check("core_rd_we", {28'h0, en_we}, 32'h0);
        check("core_rd_data", core_dtr_o, 32'hCAFE0005);

        // WB byte write into 0x12345678, then core read back
        preload(2, 32'h12345678);
        wb_txn(1'b1, 4'b0001, 32'h8, 32'h000000AB, ws0, wa0);
        check("wb_wr_lat", wa0 - ws0, 32'd3);
        check("wb_wr_we", {28'h0, en_we}, 32'h1);
        check("wb_wr_addr", {22'h0, en_addr}, 32'd2);
        core_txn(1'b0, 32'h8, 32'h0, cs0, ca0);
        check("byte_merge", core_dtr_o, 32'h123456AB);

        // Core write then read of word 0
        core_txn(1'b1, 32'h0, 32'h0000CAFE, cs0, ca0);
        check("core_wr_lat", ca0 - cs0, 32'd3);
        check("core_wr_we", {28'h0, en_we}, 32'hF);
        core_txn(1'b0, 32'h0, 32'h0, cs1, ca1);
        check("core_rd2_lat", ca1 - cs1, 32'd3);
        check("core_wr_rd_data", core_dtr_o, 32'h0000CAFE);

        // Simultaneous, continuously held requests after reset
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        preload(16, 32'h0BAD0010);
        preload(17, 32'h0BAD0011);
        order.delete();
        fork
            begin
                core_txn(1'b0, 32'h40, 32'h0, cs0, ca0);
                core_txn(1'b1, 32'h50, 32'h5A5A5A5A, cs1, ca1);
            end
            begin
                wb_txn(1'b0, 4'hF, 32'h44, 32'h0, ws0, wa0);
                wb_txn(1'b1, 4'hF, 32'h54, 32'hA5A5A5A5, ws1, wa1);
            end
        join
        check("tie_core_lat", ca0 - cs0, 32'd3);
        check("tie_wb_lat", wa0 - ws0, 32'd7);
        check("tie_core2_ack", ca1 - cs0, 32'd11);
        check("tie_wb2_ack", wa1 - ws0, 32'd15);
        check("order_n", order.size(), 32'd4);
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            check($sformatf("order_%0d", i), order[i], (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        check("tie_wb_rd_data", wbs_dat_o, 32'h0BAD0011);

        // Reset while a WB read sits in WAIT
        preload(8, 32'hDEAD0008);
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h20;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        @(posedge clk);
        #1 check("rst_issue_en", {31'h0, ram_en_o}, 32'h1);
        @(posedge clk);
        #1 check("rst_wait_busy", {31'h0, busy_o}, 32'h1);
        rst = 1'b1;
        #1 check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst       = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        check_all_zero("postrst");
        preload(6, 32'h600D0006);
        core_txn(1'b0, 32'h18, 32'h0, cs0, ca0);
        check("postrst_lat", ca0 - cs0, 32'd3);
        check("postrst_data", core_dtr_o, 32'h600D0006);
        check("postrst_wbs_dat", wbs_dat_o, 32'h0);

        // Address aliasing modulo 2^ADDR_W words
        wb_txn(1'b1, 4'hF, 32'h1000, 32'h00001111, ws0, wa0);
        check("alias_addr", {22'h0, en_addr}, 32'd0);
        core_txn(1'b0, 32'h0, 32'h0, cs0, ca0);
        check("alias_data", core_dtr_o, 32'h00001111);

        repeat (3) @(posedge clk);
        check("core_q_empty", core_q.size(), 32'd0);
        check("wb_q_empty", wb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
